recip_nr_seq: RTL and testbench
===============================

# recip_nr_seq

Iterative Newton-Raphson reciprocal sequencer built around the 4-bit reciprocal seed table `ReciprocalLUT`. It accepts a normalized U1.15 operand over a valid/ready handshake and seeds the estimate from the table. It refines the estimate with `ITERS` iterations on one shared 16x16 multiplier, then returns a U1.15 reciprocal. It sits in front of the divide path and is the only client of the seed table.

## Interface
- `ITERS`, default 2: Newton-Raphson iterations, 0 to 3; 0 returns the raw seed.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operand valid.
- `in_ready`  out  1  block can accept; equals state==IDLE.
- `in_x`  in  16  operand, U1.15, normalized when bit 15 = 1.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_y`  out  16  reciprocal, U1.15.
- `out_err`  out  1  operand was not normalized; `out_y` = 0.

## Operation
- FSM states: IDLE, SEED, ITER_A, ITER_B, DONE.
- IDLE: `in_ready`=1. On `in_valid`&&`in_ready`, latch `x` <= `in_x`.
  - If `in_x[15]`=0: set `err`, `y` <= 0, go to DONE.
  - Otherwise clear `err`, go to SEED.
- SEED: `y` <= table(`x[14:11]`); `it` <= 0.
  - ITERS=0: go to DONE. Otherwise go to ITER_A.
- ITER_A: `p` = (`x`*`y`)[30:15], where the product is 32 bits and bit 31 is always 0. `t` <= 17'h10000 − {0,`p`}, kept as 16 bits U1.15 because t<2. Go to ITER_B.
- ITER_B: `y` <= (`y`*`t`)[30:15]; `it` <= `it`+1.
  - If `it`==ITERS−1: go to DONE. Otherwise go to ITER_A.
- Both ITER states use one multiplier with a muxed operand.
- DONE: `out_valid`=1. `out_y`=`y` and `out_err`=`err` stay stable until `out_valid`&&`out_ready`, then go to IDLE.
- All products truncate and never round. No saturation is needed: the seed overestimates by at most 6.7%, so 0 < p < 2.
- Input ignored while not IDLE. A new operand is not accepted in the same cycle as the output handshake; earliest acceptance is the following cycle.

## Timing
- Reset values: state IDLE. `in_ready`=1, `out_valid`=0, `out_y`=0, `out_err`=0. Internal `x`, `y`, `t`, `it` = 0.
- Reset mid-operation discards the operand immediately. No output is produced for it.
- Latency, normalized operand: `out_valid` rises 2+2·ITERS edges after the accepting edge. ITERS=2 gives 6.
- Latency, unnormalized operand: `out_valid` rises on the edge after acceptance.
- Throughput: one operand per 3+2·ITERS cycles with `out_ready` held high.
- `out_ready` low in DONE: hold indefinitely; no output change.
- `out_y`/`out_err` are registered; no combinational path from `in_*` to `out_*`.

## Structure
- Shared package `recip_pkg`:
  - state enum `recip_state_t` (IDLE, SEED, ITER_A, ITER_B, DONE).
  - constants `RECIP_W`=16, `RECIP_FRAC`=15, `RECIP_SEED_BITS`=4, `RECIP_TWO`=17'h10000.
- One sub-module: instance of `ReciprocalLUT`. `inTW` = `x[14:11]`, `outTW` gives the seed.
- Multiplier and operand mux are inline.

## Test plan
- ITERS=2, `in_x`=16'h8000 (1.0) -> seed 16'h8000; `out_y`=16'h8000, `out_err`=0, `out_valid` 6 edges after acceptance.
- ITERS=2, `in_x`=16'hC000 (1.5) -> seed 16'h5555; p=16'h7FFF, t=16'h8001 each iteration; `out_y`=16'h5555.
- ITERS=2, `in_x`=16'hFFFF -> seed 16'h4210. Iteration 1: p=16'h841F, t=16'h7BE1, y=16'h3FEF. Iteration 2: p=16'h7FDD, t=16'h8023, y=16'h4000; `out_y`=16'h4000.
- `in_x`=16'h4000 -> `out_err`=1, `out_y`=0, `out_valid` one edge after acceptance.
- Backpressure: hold `out_ready`=0 for 10 cycles in DONE -> `out_valid`/`out_y` stable and `in_ready`=0 with `in_valid` high. Release -> IDLE next cycle; the next operand is accepted the following cycle.
- Assert `reset` while in ITER_A -> outputs return to reset values asynchronously. After release, a fresh 16'hC000 returns 16'h5555 with nominal latency.

Source files
------------

// File: rtl/recip_pkg.sv
// Shared types and constants for the Newton-Raphson reciprocal sequencer.
package recip_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEED   = 3'd1,
    ITER_A = 3'd2,
    ITER_B = 3'd3,
    DONE   = 3'd4
  } recip_state_t;

  localparam int RECIP_W         = 16;
  localparam int RECIP_FRAC      = 15;
  localparam int RECIP_SEED_BITS = 4;

  localparam logic [16:0] RECIP_TWO = 17'h10000;

endpackage

// File: rtl/ReciprocalLUT.sv
// 4-bit seed table: floor(2^15 * 16 / (16 + i)), the reciprocal of the
// low end of each operand bin, so the seed never underestimates.
module ReciprocalLUT
  import recip_pkg::*;
(
  input  logic [RECIP_SEED_BITS-1:0] inTW,
  output logic [RECIP_W-1:0]         outTW
);

  always_comb begin
    outTW = 16'h8000;
    unique case (inTW)
      4'd0:  outTW = 16'h8000;
      4'd1:  outTW = 16'h7878;
      4'd2:  outTW = 16'h71C7;
      4'd3:  outTW = 16'h6BCA;
      4'd4:  outTW = 16'h6666;
      4'd5:  outTW = 16'h6186;
      4'd6:  outTW = 16'h5D17;
      4'd7:  outTW = 16'h590B;
      4'd8:  outTW = 16'h5555;
      4'd9:  outTW = 16'h51EB;
      4'd10: outTW = 16'h4EC4;
      4'd11: outTW = 16'h4BDA;
      4'd12: outTW = 16'h4924;
      4'd13: outTW = 16'h469E;
      4'd14: outTW = 16'h4444;
      4'd15: outTW = 16'h4210;
    endcase
  end

endmodule

// File: rtl/recip_nr_seq.sv
// Iterative Newton-Raphson reciprocal: table seed, then ITERS refinements
// of y <- y*(2 - x*y) on one shared 16x16 multiplier.
module recip_nr_seq
  import recip_pkg::*;
#(
  parameter int ITERS = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [RECIP_W-1:0] in_x,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [RECIP_W-1:0] out_y,
  output logic               out_err
);

  localparam logic [1:0] LAST_IT = 2'(ITERS - 1);

  recip_state_t r_state;
  recip_state_t w_next;

  logic [RECIP_W-1:0] r_x;
  logic [RECIP_W-1:0] r_y;
  logic [RECIP_W-1:0] r_t;
  logic [1:0]         r_it;
  logic               r_err;

  logic [RECIP_W-1:0] w_seed;
  logic [RECIP_W-1:0] w_opa;
  logic [RECIP_W-1:0] w_opb;
  logic [RECIP_W-1:0] w_pmid;
  logic [RECIP_W-1:0] w_t;
  logic               w_in_acc;

  ReciprocalLUT u_lut (
    .inTW  (r_x[14:11]),
    .outTW (w_seed)
  );

  // ITER_A forms x*y, ITER_B forms y*t on the same multiplier
  assign w_opa = (r_state == ITER_A) ? r_x : r_y;
  assign w_opb = (r_state == ITER_A) ? r_y : r_t;

  assign w_pmid = 16'(({16'b0, w_opa} * {16'b0, w_opb}) >> RECIP_FRAC);
  assign w_t    = 16'(RECIP_TWO - {1'b0, w_pmid});

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign out_y     = r_y;
  assign out_err   = r_err;
  assign w_in_acc  = in_valid && in_ready;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_in_acc) begin
          w_next = in_x[15] ? SEED : DONE;
        end
      end
      SEED: begin
        w_next = (ITERS == 0) ? DONE : ITER_A;
      end
      ITER_A: begin
        w_next = ITER_B;
      end
      ITER_B: begin
        w_next = (r_it == LAST_IT) ? DONE : ITER_A;
      end
      DONE: begin
        if (out_ready) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_t     <= '0;
      r_it    <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        IDLE: begin
          if (w_in_acc) begin
            r_x   <= in_x;
            r_err <= ~in_x[15];
            if (!in_x[15]) begin
              r_y <= '0;
            end
          end
        end
        SEED: begin
          r_y  <= w_seed;
          r_it <= '0;
        end
        ITER_A: begin
          r_t <= w_t;
        end
        ITER_B: begin
          r_y  <= w_pmid;
          r_it <= r_it + 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_recip_nr_seq.sv
// Scoreboard bench for recip_nr_seq: directed operands with hand-computed
// reciprocals, latency, backpressure and mid-operation reset.
module tb_recip_nr_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_x = 16'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_y;
  logic        out_err;

  recip_nr_seq #(.ITERS(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] y;
    logic        err;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic prev_v = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, req);
    end
  endtask

  // monitor: inputs are driven just after posedge, sampled here on negedge
  always @(negedge clk) begin
    if (reset) begin
      prev_v = 1'b0;
    end else begin
      if (in_valid && in_ready) acc_q.push_back(cyc + 1);
      if (out_valid && !prev_v) begin
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_valid got y=%h err=%b", out_y, out_err);
        end else begin
          chk("latency", cyc - acc_q[0] + 1, exp_q[0].lat);
        end
      end
      if (out_valid && out_ready && exp_q.size() != 0 && acc_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        void'(acc_q.pop_front());
        chk("out_y", 32'(out_y), 32'(e.y));
        chk("out_err", 32'(out_err), 32'(e.err));
      end
      prev_v = out_valid;
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(posedge clk); #1;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout got in_ready=0 want 1");
    end
  endtask

  task automatic send(input logic [15:0] x, input logic [15:0] y,
                      input logic err, input int lat);
    exp_t e;
    wait_idle();
    e.y = y;
    e.err = err;
    e.lat = lat;
    exp_q.push_back(e);
    in_valid = 1'b1;
    in_x = x;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got %0d pending want 0", exp_q.size());
      exp_q.delete();
      acc_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int n;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_y", 32'(out_y), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    reset = 1'b0;

    send(16'h8000, 16'h8000, 1'b0, 6);
    drain();
    send(16'hC000, 16'h5555, 1'b0, 6);
    drain();
    send(16'hFFFF, 16'h4000, 1'b0, 6);
    drain();
    send(16'h4000, 16'h0000, 1'b1, 1);
    drain();
    send(16'h0000, 16'h0000, 1'b1, 1);
    drain();
    send(16'hC000, 16'h5555, 1'b0, 6);
    send(16'h8000, 16'h8000, 1'b0, 6);
    drain();

    // backpressure with the next operand already waiting
    out_ready = 1'b0;
    send(16'hC000, 16'h5555, 1'b0, 6);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_reach_done", 32'(out_valid), 32'd1);
    e.y = 16'h4000;
    e.err = 1'b0;
    e.lat = 6;
    exp_q.push_back(e);
    in_valid = 1'b1;
    in_x = 16'hFFFF;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_y", 32'(out_y), 32'h5555);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("rel_idle", 32'(in_ready), 32'd1);
    chk("rel_valid_low", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("rel_accepted", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    drain();

    // reset while in ITER_A
    wait_idle();
    e.y = 16'h5555;
    e.err = 1'b0;
    e.lat = 6;
    exp_q.push_back(e);
    in_valid = 1'b1;
    in_x = 16'hC000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_y", 32'(out_y), 32'h5555);
    reset = 1'b1;
    #1;
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_y", 32'(out_y), 32'd0);
    chk("arst_out_err", 32'(out_err), 32'd0);
    exp_q.delete();
    acc_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    send(16'hC000, 16'h5555, 1'b0, 6);
    drain();
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
